// File: rtl/fetch_window.sv
// fetch_window: byte window between the prefetch FIFO and the instruction decoder.
// Whole FIFO entries are appended behind the bytes still held; decode consumes from
// the front; a fault entry is held back until every byte fetched before it is gone.
module fetch_window #(
   parameter int LINE_BYTES = 8,
   parameter int OUT_BYTES  = 8,
   parameter int WIN_BYTES  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pr_reset,
   input  logic [31:0]             wr_eip,
   output logic [31:0]             prefetch_eip,
   output logic                    prefetchfifo_accept_do,
   input  logic [LINE_BYTES*8+3:0] prefetchfifo_accept_data,
   input  logic                    prefetchfifo_accept_empty,
   output logic [3:0]              fetch_valid,
   output logic [OUT_BYTES*8-1:0]  fetch,
   output logic                    fetch_limit,
   output logic                    fetch_page_fault,
   input  logic [3:0]              dec_acceptable
);

   localparam logic [3:0] LINE_CNT   = 4'(LINE_BYTES);
   localparam logic [3:0] OUT_CNT    = 4'(OUT_BYTES);
   localparam logic [5:0] WIN_CNT    = 6'(WIN_BYTES);
   localparam logic [3:0] CODE_PF    = 4'd14;
   localparam logic [3:0] CODE_LIMIT = 4'd15;

   logic [WIN_BYTES*8-1:0]  win_buf;
   logic [WIN_BYTES*8-1:0]  buf_shift;
   logic [WIN_BYTES*8-1:0]  buf_next;
   logic [4:0]              win_count;
   logic [4:0]              count_left;
   logic [4:0]              count_next;
   logic [5:0]              fill;
   logic                    fault_pend;
   logic                    fault_pf;
   logic [3:0]              code;
   logic [3:0]              consumed;
   logic [LINE_BYTES*8-1:0] line;
   logic                    data_pop;
   logic                    fault_pop;

   assign prefetch_eip = wr_eip;
   assign code         = prefetchfifo_accept_data[LINE_BYTES*8 +: 4];
   assign line         = prefetchfifo_accept_data[LINE_BYTES*8-1:0];

   // Present up to OUT_BYTES of the window; a pending fault with an empty window already yields zero.
   always_comb begin
      fetch_valid = (win_count < {1'b0, OUT_CNT}) ? win_count[3:0] : OUT_CNT;
      fetch       = '0;
      for (int unsigned i = 0; i < OUT_BYTES; i++) begin
         if (4'(i) < fetch_valid) fetch[i*8 +: 8] = win_buf[i*8 +: 8];
      end
   end

   // Decide this cycle's consumption and whether the FIFO head is taken whole.
   always_comb begin
      consumed   = (dec_acceptable < fetch_valid) ? dec_acceptable : fetch_valid;
      count_left = win_count - {1'b0, consumed};
      fill       = {1'b0, count_left} + {2'b00, code};
      data_pop   = !prefetchfifo_accept_empty && (code <= LINE_CNT) && !fault_pend
                   && !pr_reset && (fill <= WIN_CNT);
      fault_pop  = !prefetchfifo_accept_empty && ((code == CODE_PF) || (code == CODE_LIMIT))
                   && !fault_pend && !pr_reset;
      prefetchfifo_accept_do = data_pop | fault_pop;
      count_next = data_pop ? fill[4:0] : count_left;
   end

   // Shift out consumed bytes, then drop the popped entry in directly behind the survivors.
   always_comb begin
      buf_shift = win_buf >> {consumed, 3'b000};
      buf_next  = buf_shift;
      if (data_pop) begin
         for (int unsigned j = 0; j < LINE_BYTES; j++) begin
            if (4'(j) < code && (32'(count_left) + j) < WIN_BYTES)
               buf_next[(32'(count_left) + j)*8 +: 8] = line[j*8 +: 8];
         end
      end
   end

   // Window state register; rst outranks the pipeline flush, buffer contents need no reset.
   always_ff @(posedge clk) begin
      win_buf <= buf_next;
      if (rst) begin
         win_count  <= '0;
         fault_pend <= 1'b0;
         fault_pf   <= 1'b0;
      end else if (pr_reset) begin
         win_count  <= '0;
         fault_pend <= 1'b0;
         fault_pf   <= 1'b0;
      end else begin
         win_count <= count_next;
         if (fault_pop) begin
            fault_pend <= 1'b1;
            fault_pf   <= (code == CODE_PF);
         end
      end
   end

   assign fetch_page_fault = fault_pend &  fault_pf & (win_count == '0);
   assign fetch_limit      = fault_pend & ~fault_pf & (win_count == '0);

endmodule

// File: doc/fetch_window.md
FETCH_WINDOW -- requirements
Module: fetch_window

Interface
REQ-001 Parameter LINE_BYTES, default 8, SHALL set the data bytes per prefetch FIFO entry; legal values are 4 and 8.
REQ-002 Parameter OUT_BYTES, default 8, SHALL set the bytes presented to decode; legal range is 1..15.
REQ-003 Parameter WIN_BYTES, default 16, SHALL set the window buffer depth in bytes; legal range is max(LINE_BYTES,OUT_BYTES)..31.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 pr_reset  in  1  SHALL be the pipeline flush.
REQ-007 wr_eip  in  32  SHALL be the committed EIP.
REQ-008 prefetch_eip  out  32  SHALL be the prefetch restart EIP.
REQ-009 prefetchfifo_accept_do  out  1  SHALL pop the FIFO head this cycle.
REQ-010 prefetchfifo_accept_data  in  LINE_BYTES*8+4  SHALL carry the FIFO head: [top 4 bits] code, [LINE_BYTES*8-1:0] bytes, with byte 0 in the LSBs.
REQ-011 prefetchfifo_accept_empty  in  1  SHALL indicate that the FIFO head is invalid.
REQ-012 fetch_valid  out  4  SHALL give the count of valid bytes presented to decode.
REQ-013 fetch  out  OUT_BYTES*8  SHALL present the window bytes, oldest byte in the LSBs.
REQ-014 fetch_limit  out  1  SHALL signal a segment-limit fault reached by decode.
REQ-015 fetch_page_fault  out  1  SHALL signal a page fault reached by decode.
REQ-016 dec_acceptable  in  4  SHALL give the number of bytes decode consumes this cycle.

Function
REQ-017 Entry code SHALL be interpreted as: 0..LINE_BYTES = valid byte count, 14 = page fault, 15 = limit fault; codes LINE_BYTES+1..13 are illegal and shall be flagged by a bench assertion.
REQ-018 prefetch_eip SHALL equal wr_eip combinationally.
REQ-019 State SHALL be: win_buf (WIN_BYTES bytes, packed from byte 0), win_count (5 bits), fault_pend (1), fault_pf (1).
REQ-020 fetch_valid SHALL equal min(win_count, OUT_BYTES) when fault_pend=0 or win_count>0, and 0 otherwise.
REQ-021 fetch SHALL equal win_buf bytes 0..OUT_BYTES-1, with bytes at index >= fetch_valid forced to zero.
REQ-022 consumed SHALL equal min(dec_acceptable, fetch_valid); over-acceptance is saturated, never underflows.
REQ-023 A data pop SHALL occur when: FIFO is not empty, code <= LINE_BYTES, fault_pend=0, pr_reset=0, and win_count - consumed + code <= WIN_BYTES.
REQ-024 A fault pop SHALL occur when: FIFO is not empty, code is 14 or 15, fault_pend=0, and pr_reset=0; it sets fault_pend=1 and fault_pf=(code==14) and appends no bytes.
REQ-025 prefetchfifo_accept_do SHALL be the OR of data pop and fault pop, evaluated combinationally in the same cycle as dec_acceptable.
REQ-026 Each cycle: win_buf SHALL shift down by consumed bytes, then popped bytes shall be appended at index win_count - consumed; win_count_next = win_count - consumed + (data pop ? code : 0).
REQ-027 Simultaneous consume and append SHALL be supported in one cycle with no bubble.
REQ-028 Popped bytes SHALL be visible on fetch in the cycle after the pop (1-cycle latency).
REQ-029 An entry SHALL never be split: if it does not fully fit, it waits at the head (no pop).
REQ-030 While fault_pend=1, no further pops SHALL occur; buffered bytes before the fault still drain normally.
REQ-031 fetch_page_fault SHALL equal fault_pend & fault_pf & (win_count==0).
REQ-032 fetch_limit SHALL equal fault_pend & ~fault_pf & (win_count==0).
REQ-033 pr_reset SHALL, next cycle, clear win_count, fault_pend and fault_pf; no pop occurs in the pr_reset cycle; rst has priority over pr_reset.
REQ-034 A code-0 entry SHALL be popped with no bytes appended.
REQ-035 Byte alignment SHALL be preserved across entry boundaries: byte order on fetch equals FIFO order.

Reset
REQ-036 rst=1 SHALL, next cycle, give win_count=0, fault_pend=0, fault_pf=0, and win_buf contents don't-care.
REQ-037 After reset, outputs SHALL be: fetch_valid=0, fetch=0, fetch_limit=0, fetch_page_fault=0, prefetchfifo_accept_do=0 while the FIFO is empty.

Verification
REQ-038 Scenario: entry code 8, bytes 0x0706050403020100, dec_acceptable=0 -> pop; next cycle fetch_valid=8 and fetch=0x0706050403020100.
REQ-039 Scenario: window holds 8 bytes 00..07, dec_acceptable=3, FIFO head code 8 bytes 08..0F -> same-cycle pop; next cycle win_count=13 and fetch=0x0A09080706050403.
REQ-040 Scenario: win_count=12, dec_acceptable=0, FIFO head code 8 -> no pop; then dec_acceptable=4 -> pop; next cycle win_count=16.
REQ-041 Scenario: window holds 5 bytes, FIFO head code 14 -> fault pop; fetch_page_fault=0 until decode consumes 5 bytes, then fetch_page_fault=1 with fetch_valid=0; next head is not popped.
REQ-042 Scenario: fault pending with code 15 and 3 bytes buffered, pr_reset=1 -> accept_do=0 that cycle; next cycle win_count=0, fetch_limit=0, and pops resume.
REQ-043 Scenario: fetch_valid=2, dec_acceptable=9 -> consumed=2, win_count becomes 0, no underflow.
